// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int SDRAM_DW = 16;
    localparam int SDRAM_WM = 2;

    // Round-robin pointer successor over ports 1..n-1; port 0 never enters the rotation.
    function automatic int rr_next(input int g, input int n);
        return (g >= n - 1) ? 1 : g + 1;
    endfunction

endpackage

// File: rtl/sdram_bus.sv
// rtl/sdram_bus.sv - toggle req/ack bus between the arbiter and the SDRAM controller
interface sdram_bus
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 22
);
    logic                  req;
    logic                  ack;
    logic                  we;
    logic [ADDR_BITS-1:0]  address;
    logic [SDRAM_DW-1:0]   data_write;
    logic [SDRAM_WM-1:0]   wm;
    logic [SDRAM_DW-1:0]   data_read;

    modport controller (
        output req, we, address, data_write, wm,
        input  ack, data_read
    );

    modport device (
        input  req, we, address, data_write, wm,
        output ack, data_read
    );
endinterface

// File: rtl/sdram_arb_rr.sv
// rtl/sdram_arb_rr.sv - cyclic first-one picker over ports 1..NUM_PORTS-1 starting at ptr
module sdram_arb_rr #(
    parameter int  NUM_PORTS = 3,
    localparam int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:1] pend,
    input  logic [IW-1:0]        ptr,
    output logic [IW-1:0]        idx,
    output logic                 valid
);

    always_comb begin
        int p;
        valid = 1'b0;
        idx   = '0;
        p     = 0;
        for (int k = 0; k < NUM_PORTS - 1; k++) begin
            p = int'(ptr) + k;
            if (p > NUM_PORTS - 1) p = p - (NUM_PORTS - 1);
            if (!valid && pend[p]) begin
                valid = 1'b1;
                idx   = IW'(p);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one SDRAM controller port among NUM_PORTS toggle-handshake clients
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 3,
    parameter int  ADDR_BITS = 22,
    localparam int GW        = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS-1:0]            c_req,
    output logic [NUM_PORTS-1:0]            c_ack,
    input  logic [NUM_PORTS-1:0]            c_we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]  c_addr,
    input  logic [NUM_PORTS*SDRAM_DW-1:0]   c_wdata,
    input  logic [NUM_PORTS*SDRAM_WM-1:0]   c_wm,
    output logic [NUM_PORTS*SDRAM_DW-1:0]   c_rdata,
    sdram_bus.controller                    ram,
    output logic                            busy,
    output logic [GW-1:0]                   grant
);

    arb_state_t            state;
    logic                  req_q;
    logic                  we_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [SDRAM_DW-1:0]   wdata_q;
    logic [SDRAM_WM-1:0]   wm_q;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         rr_idx;
    logic                  rr_valid;
    logic [NUM_PORTS-1:0]  pend;
    logic [GW-1:0]         sel;
    logic                  any_pend;
    logic                  sel_we;
    logic [ADDR_BITS-1:0]  sel_addr;
    logic [SDRAM_DW-1:0]   sel_wdata;
    logic [SDRAM_WM-1:0]   sel_wm;

    assign pend = c_req ^ c_ack;

    sdram_arb_rr #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .pend  (pend[NUM_PORTS-1:1]),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    // Port 0 (PPU) overrides the rotation unconditionally.
    assign sel      = pend[0] ? '0 : rr_idx;
    assign any_pend = pend[0] | rr_valid;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wm    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (GW'(i) == sel) begin
                sel_we    = c_we[i];
                sel_addr  = c_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_wdata = c_wdata[i*SDRAM_DW +: SDRAM_DW];
                sel_wm    = c_wm[i*SDRAM_WM +: SDRAM_WM];
            end
        end
    end

    assign ram.req        = req_q;
    assign ram.we         = we_q;
    assign ram.address    = addr_q;
    assign ram.data_write = wdata_q;
    assign ram.wm         = wm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ARB_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wm_q    <= '1;
            c_ack   <= '0;
            c_rdata <= '0;
            rr_ptr  <= GW'(1);
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_pend) begin
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wm_q    <= sel_wm;
                        req_q   <= ~req_q;
                        grant   <= sel;
                        busy    <= 1'b1;
                        state   <= ARB_BUSY;
                        if (sel != '0) rr_ptr <= GW'(rr_next(int'(sel), NUM_PORTS));
                    end
                end
                ARB_BUSY: begin
                    // The completion edge never grants, leaving one idle cycle between transactions.
                    if (ram.ack == req_q) begin
                        for (int i = 0; i < NUM_PORTS; i++) begin
                            if (GW'(i) == grant) begin
                                if (!we_q) c_rdata[i*SDRAM_DW +: SDRAM_DW] <= ram.data_read;
                                c_ack[i] <= ~c_ack[i];
                            end
                        end
                        busy  <= 1'b0;
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter with an SDRAM device model
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int N  = 3;
    localparam int AB = 22;
    localparam int GW = $clog2(N);

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      c_req, c_ack, c_we;
    logic [N*AB-1:0]   c_addr;
    logic [N*16-1:0]   c_wdata, c_rdata;
    logic [N*2-1:0]    c_wm;
    logic              busy;
    logic [GW-1:0]     grant;

    sdram_bus #(.ADDR_BITS(AB)) ram_if ();

    sdram_arbiter #(.NUM_PORTS(N), .ADDR_BITS(AB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .c_req   (c_req),
        .c_ack   (c_ack),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_wm    (c_wm),
        .c_rdata (c_rdata),
        .ram     (ram_if),
        .busy    (busy),
        .grant   (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        we;
        logic [AB-1:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wm;
        logic [15:0] rdata;
        int          gcyc;
        int          acyc;
    } rec_t;

    rec_t          log_q[$];
    int            exp_ord[$];
    int            rd = 0;
    int            checks = 0, errors = 0, cyc = 0, cnt = 0, lat = 5, m_ptr = 1;
    logic          prev_req = 1'b0;
    bit            hold = 1'b0, fixed_en = 1'b0;
    logic [15:0]   fixed_data = '0;
    logic [15:0]   exp_rdata [N];
    logic          iss_we    [N];
    logic [AB-1:0] iss_addr  [N];
    logic [15:0]   iss_wdata [N];
    logic [1:0]    iss_wm    [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dev_ack();
        logic [15:0] d;
        d = fixed_en ? fixed_data : 16'($urandom);
        ram_if.data_read = d;
        ram_if.ack = ram_if.req;
        if (log_q.size() > 0) begin
            log_q[log_q.size()-1].rdata = d;
            log_q[log_q.size()-1].acyc  = cyc;
        end
    endtask

    // One negedge: record new grants and run the SDRAM device with latency lat.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            prev_req = 1'b0;
            ram_if.ack = 1'b0;
            cnt = 0;
        end else if (ram_if.req !== prev_req) begin
            rec_t r;
            r.port = int'(grant); r.we = ram_if.we; r.addr = ram_if.address;
            r.wdata = ram_if.data_write; r.wm = ram_if.wm; r.rdata = '0;
            r.gcyc = cyc; r.acyc = 0;
            log_q.push_back(r);
            prev_req = ram_if.req;
            cnt = lat;
        end else if (ram_if.req !== ram_if.ack && !hold) begin
            if (cnt <= 1) dev_ack();
            else cnt--;
        end
    endtask

    task automatic issue(input int p, input logic we, input logic [AB-1:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        c_we[p] = we;
        c_addr[p*AB +: AB] = a;
        c_wdata[p*16 +: 16] = d;
        c_wm[p*2 +: 2] = m;
        c_req[p] = ~c_req[p];
        iss_we[p] = we; iss_addr[p] = a; iss_wdata[p] = d; iss_wm[p] = m;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(c_req === c_ack && busy === 1'b0 && ram_if.req === ram_if.ack) && n < budget);
        chk({tag, "_timeout"}, 64'(n < budget), 64'(1));
    endtask

    // Checks the next logged grant against what the client issued; exp_port < 0 accepts any port.
    task automatic consume(input int exp_port, input string tag);
        rec_t r;
        int p;
        chk({tag, "_present"}, 64'(rd < log_q.size()), 64'(1));
        if (rd >= log_q.size()) return;
        r = log_q[rd];
        rd++;
        p = (exp_port < 0) ? r.port : exp_port;
        if (p < 0 || p >= N) p = 0;
        chk({tag, "_port"}, 64'(r.port), 64'(p));
        chk({tag, "_we"}, 64'(r.we), 64'(iss_we[p]));
        chk({tag, "_addr"}, 64'(r.addr), 64'(iss_addr[p]));
        if (iss_we[p]) begin
            chk({tag, "_wdata"}, 64'(r.wdata), 64'(iss_wdata[p]));
            chk({tag, "_wm"}, 64'(r.wm), 64'(iss_wm[p]));
        end else begin
            exp_rdata[p] = r.rdata;
        end
        if (p != 0) m_ptr = (p == N - 1) ? 1 : p + 1;
    endtask

    task automatic check_rdata(input string tag);
        for (int i = 0; i < N; i++) chk({tag, "_rdata"}, 64'(c_rdata[i*16 +: 16]), 64'(exp_rdata[i]));
    endtask

    // Expected service order for a set of requests all raised in one cycle while idle.
    task automatic predict(input logic [N-1:0] mask);
        exp_ord.delete();
        if (mask[0]) exp_ord.push_back(0);
        for (int k = 0; k < N - 1; k++) begin
            int p;
            p = ((m_ptr - 1 + k) % (N - 1)) + 1;
            if (mask[p]) exp_ord.push_back(p);
        end
    endtask

    initial begin
        int t0, rd0, n;
        bit seen0;
        logic [N-1:0] mask;
        reset_n = 1'b0;
        c_req = '1; c_we = '0; c_addr = '0; c_wdata = '0; c_wm = '0;
        ram_if.ack = 1'b0; ram_if.data_read = '0;
        for (int i = 0; i < N; i++) begin
            exp_rdata[i] = '0; iss_we[i] = 1'b0; iss_addr[i] = '0; iss_wdata[i] = '0; iss_wm[i] = '0;
        end

        // Reset with all requests raised, then quiet after release
        repeat (3) step();
        chk("rst_ack", 64'(c_ack), 64'(0));
        chk("rst_req", 64'(ram_if.req), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_wm", 64'(ram_if.wm), 64'(3));
        check_rdata("rst");
        c_req = '0;
        reset_n = 1'b1;
        repeat (20) step();
        chk("quiet_no_grant", 64'(log_q.size()), 64'(0));
        chk("quiet_req", 64'(ram_if.req), 64'(0));

        // Single read on port 1; later field changes must not disturb it
        fixed_en = 1'b1; fixed_data = 16'hBEEF; lat = 5;
        t0 = cyc;
        issue(1, 1'b0, 22'h12345, 16'h0000, 2'b00);
        n = 0;
        while (log_q.size() == 0 && n < 10) begin step(); n++; end
        chk("read_grant_seen", 64'(log_q.size()), 64'(1));
        if (log_q.size() > 0) chk("read_latency", 64'(log_q[0].gcyc - t0), 64'(1));
        c_addr[AB +: AB] = 22'h3FFFF; c_we[1] = 1'b1;
        step(); step();
        chk("addr_hold", 64'(ram_if.address), 64'(22'h12345));
        wait_idle(50, "read1");
        consume(1, "read1");
        chk("read1_data", 64'(c_rdata[16 +: 16]), 64'(16'hBEEF));
        check_rdata("read1");

        // Write on port 2
        fixed_en = 1'b0;
        issue(2, 1'b1, 22'h00ABC, 16'hA55A, 2'b01);
        wait_idle(50, "write2");
        consume(2, "write2");
        chk("write2_ack", 64'(c_ack[2]), 64'(1));
        check_rdata("write2");

        // Simultaneous requests on all ports, one idle cycle between grants
        rd0 = rd;
        predict(3'b111);
        for (int p = 0; p < N; p++) issue(p, 1'b0, AB'($urandom), 16'($urandom), 2'($urandom));
        wait_idle(200, "all3");
        chk("all3_order_0", 64'(exp_ord[0]), 64'(0));
        for (int k = 0; k < exp_ord.size(); k++) consume(exp_ord[k], "all3");
        for (int k = rd0; k + 1 < rd; k++) chk("all3_gap", 64'(log_q[k+1].gcyc - log_q[k].acyc), 64'(2));
        check_rdata("all3");

        // Port 0 re-requests one cycle after each ack, ports 1/2 immediately
        rd0 = log_q.size();
        seen0 = 1'b0;
        for (int p = 0; p < N; p++) issue(p, 1'b0, AB'($urandom), 16'($urandom), 2'($urandom));
        n = 0;
        while (log_q.size() - rd0 < 6 && n < 600) begin
            step();
            n++;
            if (c_ack[0] === c_req[0]) begin
                if (seen0) begin c_req[0] = ~c_req[0]; seen0 = 1'b0; end
                else seen0 = 1'b1;
            end
            for (int p = 1; p < N; p++) if (c_ack[p] === c_req[p]) c_req[p] = ~c_req[p];
        end
        chk("rrseq_timeout", 64'(n < 600), 64'(1));
        wait_idle(300, "rrseq_drain");
        consume(0, "rrseq0"); consume(1, "rrseq1"); consume(0, "rrseq2");
        consume(2, "rrseq3"); consume(0, "rrseq4"); consume(1, "rrseq5");
        while (rd < log_q.size()) consume(-1, "rrseq_tail");
        check_rdata("rrseq");

        // Port 1 raised on the edge that completes port 2
        hold = 1'b1;
        rd0 = log_q.size();
        issue(2, 1'b0, AB'($urandom), 16'($urandom), 2'b00);
        n = 0;
        while (log_q.size() == rd0 && n < 10) begin step(); n++; end
        repeat (3) step();
        step();
        dev_ack();
        issue(1, 1'b0, AB'($urandom), 16'($urandom), 2'b00);
        hold = 1'b0;
        wait_idle(50, "sameedge");
        consume(2, "sameedge_a");
        consume(1, "sameedge_b");
        if (log_q.size() >= rd0 + 2)
            chk("sameedge_gap", 64'(log_q[rd0+1].gcyc - log_q[rd0].acyc), 64'(2));
        check_rdata("sameedge");

        // Randomized batches against the order/data model
        for (int b = 0; b < 40; b++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            lat = $urandom_range(1, 6);
            predict(mask);
            for (int p = 0; p < N; p++)
                if (mask[p]) issue(p, 1'($urandom_range(0, 1)), AB'($urandom), 16'($urandom), 2'($urandom));
            wait_idle(300, "rand");
            for (int k = 0; k < exp_ord.size(); k++) consume(exp_ord[k], "rand");
            chk("rand_no_extra", 64'(log_q.size() - rd), 64'(0));
            chk("rand_acks", 64'(c_ack), 64'(c_req));
            check_rdata("rand");
        end

        // Reset asserted mid-transaction
        hold = 1'b1; lat = 5;
        rd0 = log_q.size();
        issue(0, 1'b0, AB'($urandom), 16'($urandom), 2'b00);
        n = 0;
        while (log_q.size() == rd0 && n < 10) begin step(); n++; end
        step();
        chk("midrst_busy_before", 64'(busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_req", 64'(ram_if.req), 64'(0));
        chk("midrst_ack", 64'(c_ack), 64'(0));
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_we", 64'(ram_if.we), 64'(0));
        chk("midrst_addr", 64'(ram_if.address), 64'(0));
        chk("midrst_wdata", 64'(ram_if.data_write), 64'(0));
        chk("midrst_wm", 64'(ram_if.wm), 64'(3));
        chk("midrst_rdata", 64'(c_rdata), 64'(0));
        c_req = '0;
        repeat (3) step();
        reset_n = 1'b1;
        hold = 1'b0;
        rd = log_q.size();
        m_ptr = 1;
        for (int i = 0; i < N; i++) exp_rdata[i] = '0;
        step();
        fixed_en = 1'b1; fixed_data = 16'h5A3C;
        issue(0, 1'b0, 22'h2AAAA, 16'h0000, 2'b00);
        wait_idle(50, "postrst");
        consume(0, "postrst");
        chk("postrst_data", 64'(c_rdata[15:0]), 64'(16'h5A3C));
        check_rdata("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
